qrisc32_mem_stage: RTL and testbench
====================================

Name: qrisc32_mem_stage

Overview:
Memory-access pipeline stage placed directly after the execute stage. It consumes the execute pipe register (risc_pack::pipe_struct) and the execute stage's branch-redirect outputs. It performs load/store transactions on a req/ack data-memory port and stalls upstream while a transaction is outstanding. It delivers a registered pipe_struct to write-back and a registered jump redirect to fetch.

Parameters:
TIMEOUT_CYCLES, 16, number of ACCESS-state cycles without dmem_ack before the transaction aborts (legal range >=2).
CHECK_ALIGN, 1, when 1, a memory op with addr[1:0]!=0 is rejected without issuing a request.

Ports:
clk  input  1  clock, all state changes on posedge
reset  input  1  asynchronous, active-high reset
pipe_stall  input  1  global pipeline freeze
pipe_mem_in  input  risc_pack::pipe_struct  execute-stage output; val_r1=address, val_r2=store data, read_mem/write_mem=op flags
new_address_valid  input  1  branch redirect valid from execute
new_address  input  32  branch target from execute
pipe_mem_out  output  risc_pack::pipe_struct  registered result to write-back
mem_stall  output  1  upstream hold request
jump_valid  output  1  registered redirect valid to fetch
jump_address  output  32  registered redirect target to fetch
dmem_req  output  1  data-memory request
dmem_we  output  1  1=write, 0=read
dmem_addr  output  32  data-memory byte address
dmem_wdata  output  32  store data
dmem_ack  input  1  completion; sampled on posedge
dmem_rdata  input  32  load data, valid with dmem_ack
bus_error  output  1  one-cycle pulse on timeout or misalignment

Behaviour:
- Reset (async): state=IDLE, timeout counter=0. Outputs dmem_req, dmem_we, dmem_addr, dmem_wdata, jump_valid, jump_address and bus_error are 0. pipe_mem_out is all-zero (bubble). mem_stall=0. Any transaction in progress is abandoned; dmem_req drops immediately.
- mem_stall is combinational: (state==ACCESS).
- States: IDLE and ACCESS.
- IDLE, pipe_stall=1: pipe_mem_out holds its value; no access starts.
- IDLE, pipe_stall=0, no memory op: pipe_mem_out <= pipe_mem_in (latency 1).
- IDLE, pipe_stall=0, memory op (read_mem|write_mem):
  - Capture pipe_mem_in in an internal holding register.
  - Next cycle: dmem_req=1, dmem_addr=val_r1, dmem_wdata=val_r2, dmem_we=write_mem. Counter=0. Enter ACCESS.
  - pipe_mem_out <= bubble (all-zero).
  - If both read_mem and write_mem are set, the op is treated as a write.
- Misaligned op (CHECK_ALIGN=1 and val_r1[1:0]!=0): no request is issued. Next cycle bus_error=1 for one cycle and pipe_mem_out=bubble. State stays IDLE.
- ACCESS:
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable until the ack is sampled.
  - pipe_mem_in is ignored.
  - The counter increments each cycle.
- ACCESS, dmem_ack=1 on a posedge:
  - dmem_req<=0. pipe_mem_out <= held pipe.
  - For a read, val_dst is replaced with dmem_rdata. For a write, the held pipe passes through unchanged.
  - State<=IDLE. mem_stall is therefore low from the next cycle.
  - The ack updates pipe_mem_out regardless of pipe_stall.
- ACCESS, counter reaches TIMEOUT_CYCLES-1 with no ack: dmem_req<=0, bus_error pulses for one cycle, pipe_mem_out<=bubble, state<=IDLE.
- Ack and timeout on the same edge: the ack wins and no bus_error is raised.
- dmem_ack while in IDLE (late or spurious) is ignored.
- Back-to-back memory ops: the second op is issued no earlier than the cycle after returning to IDLE. It is held upstream by mem_stall until then.
- Redirect path:
  - jump_valid <= new_address_valid every cycle, independent of state and pipe_stall.
  - jump_address <= new_address when new_address_valid=1; otherwise it holds.

Test Plan:
- Non-memory op: pipe_mem_in with val_dst=0x1234, no mem flags -> pipe_mem_out.val_dst=0x1234 one cycle later; mem_stall stays 0.
- Load: val_r1=0x100, read_mem=1; ack arrives on the 3rd ACCESS cycle with rdata=0xDEADBEEF -> dmem_req held high 3 cycles at addr 0x100 with we=0; pipe_mem_out.val_dst=0xDEADBEEF; mem_stall high exactly 3 cycles.
- Store then load back-to-back: store addr 0x200, data 0xA5A5A5A5, then load 0x200 -> the second req starts only after the first ack; the load completes with the returned data; no request overlap.
- Timeout: read at 0x40, no ack, TIMEOUT_CYCLES=16 -> req drops after 16 cycles; bus_error is a 1-cycle pulse; output is a bubble. An ack on cycle 16 instead -> normal completion, no bus_error.
- Misaligned: write at 0x102 -> dmem_req never asserts; bus_error pulses once; state stays IDLE.
- Reset mid-ACCESS, then a late ack: dmem_req goes to 0 asynchronously and all outputs reset; the late ack causes no output change. Separately, new_address_valid=1 with new_address=0x80 -> jump_valid=1 and jump_address=0x80 one cycle later.

Source files
------------

// File: rtl/qrisc32_mem_stage.sv
// qrisc32 memory-access stage: runs load/store transactions on a req/ack port,
// holds the pipe upstream while a transaction is outstanding, registers the redirect.
package risc_pack;
    typedef struct packed {
        logic [31:0] val_r1;
        logic [31:0] val_r2;
        logic [31:0] val_dst;
        logic [4:0]  dst_reg;
        logic        write_reg;
        logic        read_mem;
        logic        write_mem;
    } pipe_struct;
endpackage

module qrisc32_mem_stage
    import risc_pack::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter bit CHECK_ALIGN    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_stall,
    input  pipe_struct  pipe_mem_in,
    input  logic        new_address_valid,
    input  logic [31:0] new_address,
    output pipe_struct  pipe_mem_out,
    output logic        mem_stall,
    output logic        jump_valid,
    output logic [31:0] jump_address,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        bus_error
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    pipe_struct       held_p0;
    logic             mem_op, start, misalign_hit, ack_done, tmo;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return CHECK_ALIGN && (addr[1:0] != 2'b00);
    endfunction

    // A read replaces the destination value; a write passes the held pipe through.
    function automatic pipe_struct load_merge(input pipe_struct p, input logic we,
                                              input logic [31:0] rdata);
        pipe_struct r;
        r = p;
        if (!we)
            r.val_dst = rdata;
        return r;
    endfunction

    assign mem_stall = (state == ACCESS);

    always_comb begin
        state_nxt    = state;
        start        = 1'b0;
        misalign_hit = 1'b0;
        ack_done     = 1'b0;
        tmo          = 1'b0;
        mem_op       = pipe_mem_in.read_mem | pipe_mem_in.write_mem;
        case (state)
            IDLE: begin
                if (!pipe_stall && mem_op) begin
                    if (is_misaligned(pipe_mem_in.val_r1)) begin
                        misalign_hit = 1'b1;
                    end else begin
                        start     = 1'b1;
                        state_nxt = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // Ack on the final counted cycle still completes normally.
                if (dmem_ack) begin
                    ack_done  = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    tmo       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Issue/complete stage: bus signals, result register, error pulse and redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            pipe_mem_out <= '0;
            bus_error    <= 1'b0;
            jump_valid   <= 1'b0;
            jump_address <= '0;
        end else begin
            bus_error  <= misalign_hit | tmo;
            jump_valid <= new_address_valid;
            if (new_address_valid)
                jump_address <= new_address;

            if (state == ACCESS)
                cnt <= cnt + 1'b1;

            if (start) begin
                dmem_req     <= 1'b1;
                dmem_we      <= pipe_mem_in.write_mem;
                dmem_addr    <= pipe_mem_in.val_r1;
                dmem_wdata   <= pipe_mem_in.val_r2;
                cnt          <= '0;
                pipe_mem_out <= '0;
            end else if (ack_done) begin
                dmem_req     <= 1'b0;
                pipe_mem_out <= load_merge(held_p0, dmem_we, dmem_rdata);
            end else if (tmo || misalign_hit) begin
                dmem_req     <= 1'b0;
                pipe_mem_out <= '0;
            end else if (state == IDLE && !pipe_stall) begin
                pipe_mem_out <= pipe_mem_in;
            end
        end
    end

    // Holding register for the op in flight; only meaningful while in ACCESS.
    always_ff @(posedge clk) begin
        if (start)
            held_p0 <= pipe_mem_in;
    end

endmodule

// File: tb/tb_qrisc32_mem_stage.sv
// Self-checking bench for qrisc32_mem_stage: scoreboarded pipe results plus
// a data-memory responder with programmable ack latency.
module tb_qrisc32_mem_stage;
    import risc_pack::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_stall;
    pipe_struct  pipe_mem_in;
    logic        new_address_valid;
    logic [31:0] new_address;
    pipe_struct  pipe_mem_out;
    logic        mem_stall, jump_valid, dmem_req, dmem_we, bus_error;
    logic [31:0] jump_address, dmem_addr, dmem_wdata;
    logic        resp_ack, spur_ack;
    logic [31:0] resp_rdata;
    logic        dmem_ack;

    assign dmem_ack = resp_ack | spur_ack;

    qrisc32_mem_stage #(.TIMEOUT_CYCLES(16), .CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .reset(reset), .pipe_stall(pipe_stall), .pipe_mem_in(pipe_mem_in),
        .new_address_valid(new_address_valid), .new_address(new_address),
        .pipe_mem_out(pipe_mem_out), .mem_stall(mem_stall), .jump_valid(jump_valid),
        .jump_address(jump_address), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(resp_rdata), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    pipe_struct  sb_q[$];
    pipe_struct  prev_out;
    logic [31:0] mem [logic [31:0]];
    int          ack_lat;
    int          req_run, last_req_len, n_txn, stall_cycles, berr_cycles;
    logic [31:0] last_addr;
    logic        last_we;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic pipe_struct mk(input logic [31:0] r1, input logic [31:0] r2,
                                      input logic [31:0] dst, input logic rd,
                                      input logic wr, input logic [4:0] dreg);
        pipe_struct p;
        p.val_r1    = r1;
        p.val_r2    = r2;
        p.val_dst   = dst;
        p.dst_reg   = dreg;
        p.write_reg = 1'b1;
        p.read_mem  = rd;
        p.write_mem = wr;
        return p;
    endfunction

    // One clock: advance to the falling edge, then run responder and monitor.
    task automatic tick();
        @(negedge clk);
        if (dmem_req) begin
            req_run++;
            if (ack_lat != 0 && req_run == ack_lat) begin
                resp_ack   = 1'b1;
                resp_rdata = mem.exists(dmem_addr) ? mem[dmem_addr] : 32'h0;
                last_addr  = dmem_addr;
                last_we    = dmem_we;
                if (dmem_we)
                    mem[dmem_addr] = dmem_wdata;
            end else begin
                resp_ack = 1'b0;
            end
        end else begin
            if (req_run != 0) begin
                last_req_len = req_run;
                n_txn++;
            end
            req_run  = 0;
            resp_ack = 1'b0;
        end
        if (mem_stall) stall_cycles++;
        if (bus_error) berr_cycles++;
        if (pipe_mem_out.write_reg && pipe_mem_out !== prev_out) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", 128'(pipe_mem_out), 128'(0));
            end else begin
                chk("sb_out", 128'(pipe_mem_out), 128'(sb_q.pop_front()));
            end
        end
        prev_out = pipe_mem_out;
    endtask

    task automatic issue(input pipe_struct p);
        int n;
        n = 0;
        pipe_mem_in = p;
        while (mem_stall && n < 64) begin
            tick();
            n++;
        end
        chk("issue_wait", 128'(n < 64), 128'(1));
        tick();
        pipe_mem_in = '0;
    endtask

    task automatic wait_txn(input int target);
        int n;
        n = 0;
        while (n_txn < target && n < 200) begin
            tick();
            n++;
        end
        chk("txn_wait", 128'(n_txn >= target), 128'(1));
        tick();
        tick();
    endtask

    pipe_struct p, e;
    int s0, b0, t0;

    initial begin
        reset = 1'b1; pipe_stall = 1'b0; pipe_mem_in = '0;
        new_address_valid = 1'b0; new_address = '0;
        resp_ack = 1'b0; spur_ack = 1'b0; resp_rdata = '0;
        prev_out = '0; ack_lat = 0; req_run = 0; last_req_len = 0; n_txn = 0;
        stall_cycles = 0; berr_cycles = 0; last_addr = '0; last_we = 1'b0;
        mem[32'h100] = 32'hDEADBEEF;
        tick(); tick();
        chk("rst_req", 128'(dmem_req), 128'(0));
        chk("rst_stall", 128'(mem_stall), 128'(0));
        chk("rst_out", 128'(pipe_mem_out), 128'(0));
        chk("rst_berr", 128'(bus_error), 128'(0));
        chk("rst_jv", 128'(jump_valid), 128'(0));
        chk("rst_ja", 128'(jump_address), 128'(0));
        reset = 1'b0;
        tick();

        // Non-memory op, latency 1.
        p = mk(32'h0, 32'h0, 32'h1234, 1'b0, 1'b0, 5'd3);
        sb_q.push_back(p);
        issue(p);
        chk("nm_out", 128'(pipe_mem_out), 128'(p));
        chk("nm_stall", 128'(mem_stall), 128'(0));
        tick();

        // Load with ack on the 3rd ACCESS cycle.
        ack_lat = 3; s0 = stall_cycles; b0 = berr_cycles; t0 = n_txn;
        p = mk(32'h100, 32'h0, 32'h55, 1'b1, 1'b0, 5'd4);
        e = p; e.val_dst = 32'hDEADBEEF;
        sb_q.push_back(e);
        issue(p);
        wait_txn(t0 + 1);
        chk("ld_len", 128'(last_req_len), 128'(3));
        chk("ld_addr", 128'(last_addr), 128'(32'h100));
        chk("ld_we", 128'(last_we), 128'(0));
        chk("ld_stall", 128'(stall_cycles - s0), 128'(3));
        chk("ld_berr", 128'(berr_cycles - b0), 128'(0));

        // Store then load back-to-back at the same address.
        ack_lat = 2; s0 = stall_cycles; t0 = n_txn;
        p = mk(32'h200, 32'hA5A5A5A5, 32'h77, 1'b0, 1'b1, 5'd5);
        sb_q.push_back(p);
        issue(p);
        p = mk(32'h200, 32'h0, 32'h88, 1'b1, 1'b0, 5'd6);
        e = p; e.val_dst = 32'hA5A5A5A5;
        sb_q.push_back(e);
        issue(p);
        wait_txn(t0 + 2);
        chk("b2b_txn", 128'(n_txn - t0), 128'(2));
        chk("b2b_stall", 128'(stall_cycles - s0), 128'(4));
        chk("b2b_we", 128'(last_we), 128'(0));
        chk("b2b_mem", 128'(mem[32'h200]), 128'(32'hA5A5A5A5));

        // Timeout with no ack.
        ack_lat = 0; s0 = stall_cycles; b0 = berr_cycles; t0 = n_txn;
        issue(mk(32'h40, 32'h0, 32'h99, 1'b1, 1'b0, 5'd7));
        wait_txn(t0 + 1);
        chk("to_len", 128'(last_req_len), 128'(16));
        chk("to_stall", 128'(stall_cycles - s0), 128'(16));
        chk("to_berr", 128'(berr_cycles - b0), 128'(1));
        chk("to_out", 128'(pipe_mem_out), 128'(0));

        // Ack on the final counted cycle completes normally.
        ack_lat = 16; b0 = berr_cycles; t0 = n_txn;
        mem[32'h44] = 32'h0BADF00D;
        p = mk(32'h44, 32'h0, 32'h11, 1'b1, 1'b0, 5'd8);
        e = p; e.val_dst = 32'h0BADF00D;
        sb_q.push_back(e);
        issue(p);
        wait_txn(t0 + 1);
        chk("ack16_len", 128'(last_req_len), 128'(16));
        chk("ack16_berr", 128'(berr_cycles - b0), 128'(0));

        // Misaligned store: no request, one error pulse.
        ack_lat = 2; b0 = berr_cycles; t0 = n_txn;
        issue(mk(32'h102, 32'h1, 32'h22, 1'b0, 1'b1, 5'd9));
        chk("mis_berr1", 128'(bus_error), 128'(1));
        chk("mis_out", 128'(pipe_mem_out), 128'(0));
        chk("mis_stall", 128'(mem_stall), 128'(0));
        tick();
        chk("mis_berr0", 128'(bus_error), 128'(0));
        tick(); tick();
        chk("mis_txn", 128'(n_txn - t0), 128'(0));
        chk("mis_berrcnt", 128'(berr_cycles - b0), 128'(1));

        // pipe_stall holds the result register.
        p = mk(32'h0, 32'h0, 32'hCAFE, 1'b0, 1'b0, 5'd10);
        sb_q.push_back(p);
        issue(p);
        e = mk(32'h0, 32'h0, 32'hBEEF, 1'b0, 1'b0, 5'd11);
        sb_q.push_back(e);
        pipe_stall = 1'b1; pipe_mem_in = e;
        tick(); tick();
        chk("stall_hold", 128'(pipe_mem_out), 128'(p));
        pipe_stall = 1'b0;
        tick();
        chk("stall_rel", 128'(pipe_mem_out), 128'(e));
        pipe_mem_in = '0;
        tick();

        // Redirect path.
        new_address_valid = 1'b1; new_address = 32'h80;
        tick();
        chk("jv1", 128'(jump_valid), 128'(1));
        chk("ja1", 128'(jump_address), 128'(32'h80));
        new_address_valid = 1'b0; new_address = 32'h999;
        tick();
        chk("jv0", 128'(jump_valid), 128'(0));
        chk("ja_hold", 128'(jump_address), 128'(32'h80));

        // Asynchronous reset mid-ACCESS, then a late ack.
        ack_lat = 0;
        issue(mk(32'h300, 32'h0, 32'h33, 1'b1, 1'b0, 5'd12));
        tick();
        chk("pre_rst_req", 128'(dmem_req), 128'(1));
        #2 reset = 1'b1;
        #1;
        chk("arst_req", 128'(dmem_req), 128'(0));
        chk("arst_stall", 128'(mem_stall), 128'(0));
        chk("arst_ja", 128'(jump_address), 128'(0));
        tick();
        reset = 1'b0;
        spur_ack = 1'b1; resp_rdata = 32'h12345678;
        tick();
        spur_ack = 1'b0;
        tick();
        chk("late_req", 128'(dmem_req), 128'(0));
        chk("late_out", 128'(pipe_mem_out), 128'(0));
        chk("late_berr", 128'(bus_error), 128'(0));
        chk("late_stall", 128'(mem_stall), 128'(0));

        chk("sb_empty", 128'(sb_q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit expired");
    end

endmodule
